// File: rtl/sram_bank_ctrl_if.sv
// Request/response bundle between a memory master and sram_bank_ctrl.
// Latency: none (wires only).
// Backpressure: the master may issue only while ready is high; done and err are one-cycle pulses.
`timescale 1ns/1ps
interface sram_bank_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 19
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ready, done, err, rdata);
  modport slave  (input req, we, addr, wdata, output ready, done, err, rdata);
endinterface

// File: rtl/sram_bank_ctrl.sv
// Multi-bank async-SRAM controller: bank decode from the upper address bits, setup/access/hold strobe sequencing.
// Latency: done in cycle 3+WAIT_CYC after acceptance (writes 5+2*WAIT_CYC with SRAM_WRITE_VERIFY_EN); bad bank in cycle 1.
// Backpressure: ready is low from acceptance until back in IDLE; req while busy is ignored, not queued.
`timescale 1ns/1ps
module sram_bank_ctrl #(
  parameter  int DATA_W    = 16,
  parameter  int BANK_AW   = 18,
  parameter  int NUM_BANKS = 2,
  parameter  int WAIT_CYC  = 1,
  localparam int SEL_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int ADDR_W    = SEL_W + BANK_AW
) (
  input  logic                           clk,
  input  logic                           rst,
  sram_bank_ctrl_if.slave                bus,
  output logic [NUM_BANKS-1:0]           ram_en_n,
  output logic [NUM_BANKS-1:0]           ram_oe_n,
  output logic [NUM_BANKS-1:0]           ram_we_n,
  output logic [NUM_BANKS*BANK_AW-1:0]   ram_addr,
  inout  wire  [NUM_BANKS*DATA_W-1:0]    ram_data
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACCESS  = 3'd2,
`ifdef SRAM_WRITE_VERIFY_EN
    VSETUP  = 3'd3,
    VACCESS = 3'd4,
`endif
    FINISH  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q;
  logic                bad_q;
  logic [SEL_W-1:0]    bank_q;
  logic [BANK_AW-1:0]  waddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic [NUM_BANKS-1:0] drv;
  logic [DATA_W-1:0]   rd_word;

  logic [SEL_W-1:0]    bank_in;
  logic                bank_bad;
  logic                accept;

  assign bank_in  = bus.addr[ADDR_W-1 -: SEL_W];
  assign bank_bad = (int'(bank_in) >= NUM_BANKS);
  assign accept   = (state_q == IDLE) && bus.req;

  assign bus.ready = (state_q == IDLE);
  assign bus.done  = (state_q == FINISH);
  assign bus.err   = (state_q == FINISH) && err_q;
  assign bus.rdata = rdata_q;

  // State and wait-counter registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: bad banks skip straight to FINISH; ACCESS holds for WAIT_CYC+1 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          if (bank_bad) begin
            state_d = FINISH;
          end else begin
            state_d = SETUP;
            cnt_d   = 4'(WAIT_CYC);
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (cnt_q == 4'd0) begin
`ifdef SRAM_WRITE_VERIFY_EN
          if (we_q) begin
            state_d = VSETUP;
            cnt_d   = 4'(WAIT_CYC);
          end else begin
            state_d = FINISH;
          end
`else
          state_d = FINISH;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`ifdef SRAM_WRITE_VERIFY_EN
      VSETUP: state_d = VACCESS;
      VACCESS: begin
        if (cnt_q == 4'd0) state_d = FINISH;
        else               cnt_d   = cnt_q - 4'd1;
      end
`endif
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch at acceptance, read capture on the edge leaving the last access cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      bad_q   <= 1'b0;
      bank_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= bus.we;
        bad_q   <= bank_bad;
        bank_q  <= bank_in;
        waddr_q <= bus.addr[BANK_AW-1:0];
        wdata_q <= bus.wdata;
        err_q   <= bank_bad;
      end
      if (state_q == ACCESS && cnt_q == 4'd0 && !we_q) begin
        rdata_q <= rd_word;
      end
`ifdef SRAM_WRITE_VERIFY_EN
      if (state_q == VACCESS && cnt_q == 4'd0) begin
        rdata_q <= rd_word;
        err_q   <= (rd_word != wdata_q);
      end
`endif
    end
  end

  // Read-data mux from the currently selected bank.
  always_comb begin
    rd_word = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_q == SEL_W'(b)) rd_word = ram_data[b*DATA_W +: DATA_W];
    end
  end

  // Per-bank strobes, address and write-drive enable; idle banks stay fully deasserted.
  always_comb begin
    ram_en_n = '1;
    ram_oe_n = '1;
    ram_we_n = '1;
    ram_addr = '0;
    drv      = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (state_q != IDLE && !bad_q && bank_q == SEL_W'(b)) begin
        ram_en_n[b]                   = 1'b0;
        ram_addr[b*BANK_AW +: BANK_AW] = waddr_q;
        if (!we_q && (state_q == SETUP || state_q == ACCESS)) ram_oe_n[b] = 1'b0;
`ifdef SRAM_WRITE_VERIFY_EN
        if (state_q == VSETUP || state_q == VACCESS)          ram_oe_n[b] = 1'b0;
        if (we_q && (state_q == SETUP || state_q == ACCESS))  drv[b]      = 1'b1;
`else
        if (we_q && (state_q == SETUP || state_q == ACCESS || state_q == FINISH)) drv[b] = 1'b1;
`endif
        if (we_q && state_q == ACCESS)                        ram_we_n[b] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bus
    assign ram_data[g*DATA_W +: DATA_W] = drv[g] ? wdata_q : {DATA_W{1'bz}};
  end

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Scoreboard bench for sram_bank_ctrl with a behavioural SRAM array per bank.
// Latency: expected done cycle derived from the transaction type and WAIT_CYC.
// Backpressure: driver waits on ready (bounded) and optionally holds req high for back-to-back accepts.
`timescale 1ns/1ps
module tb_sram_bank_ctrl;
  localparam int DW   = 16;
  localparam int BAW  = 18;
  localparam int NB   = 3;
  localparam int W    = 1;
  localparam int SELW = 2;
  localparam int AW   = SELW + BAW;
`ifdef SRAM_WRITE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  sram_bank_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  wire [NB-1:0]     en_n, oe_n, we_n;
  wire [NB*BAW-1:0] raddr;
  wire [NB*DW-1:0]  rdat;

  sram_bank_ctrl #(.DATA_W(DW), .BANK_AW(BAW), .NUM_BANKS(NB), .WAIT_CYC(W)) dut (
    .clk(clk), .rst(rst_n), .bus(bus),
    .ram_en_n(en_n), .ram_oe_n(oe_n), .ram_we_n(we_n),
    .ram_addr(raddr), .ram_data(rdat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Board SRAM model: 16 words per bank, optional stuck-at-0 bits per bank.
  logic [DW-1:0] dmem  [NB][16];
  logic [DW-1:0] stuck [NB];
  for (genvar g = 0; g < NB; g++) begin : g_sram
    assign rdat[g*DW +: DW] = (!en_n[g] && !oe_n[g]) ? dmem[g][raddr[g*BAW +: 4]] : {DW{1'bz}};
  end
  always @(negedge clk) begin
    for (int b = 0; b < NB; b++)
      if (!en_n[b] && !we_n[b]) dmem[b][raddr[b*BAW +: 4]] = rdat[b*DW +: DW] & ~stuck[b];
  end

  // Reference model and scoreboard.
  typedef struct {
    int            acc;
    int            lat;
    bit            err;
    logic [DW-1:0] rd;
    int            bank;
    bit            bad;
    bit            we;
    logic [BAW-1:0] wa;
  } exp_t;

  logic [DW-1:0] rmem [NB][16];
  logic [DW-1:0] last_rd = '0;
  exp_t q[$];
  int errors = 0, checks = 0;
  int en_cnt = 0, oe_cnt = 0, we_cnt = 0;
  int burst_prev = -1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle bus checks and done-pulse scoreboard compare.
  always @(negedge clk) begin
    logic [NB*BAW-1:0] ea;
    bit   idle_ok;
    bit   has;
    exp_t cur;
    ea      = '0;
    idle_ok = 1'b1;
    has     = (q.size() != 0);
    cur     = has ? q[0] : '{default: 0};
    for (int b = 0; b < NB; b++) begin
      if (has && !cur.bad && cur.bank == b) begin
        ea[b*BAW +: BAW] = cur.wa;
        if (!en_n[b]) en_cnt++;
        if (!oe_n[b]) oe_cnt++;
        if (!we_n[b]) we_cnt++;
      end else if (!(en_n[b] && oe_n[b] && we_n[b])) begin
        idle_ok = 1'b0;
      end
    end
    chk("ram_addr", raddr, ea);
    chk("idle_strobes", idle_ok, 1);
    if (bus.done) begin
      if (!has) begin
        chk("spurious_done", 1, 0);
      end else begin
        void'(q.pop_front());
        chk("latency", cyc - cur.acc, cur.lat);
        chk("err", bus.err, cur.err);
        chk("rdata", bus.rdata, cur.rd);
        chk("en_cycles", en_cnt, cur.bad ? 0 : (3 + W + ((VERIFY && cur.we) ? 2 + W : 0)));
        chk("oe_cycles", oe_cnt, cur.bad ? 0 : (cur.we ? (VERIFY ? W + 2 : 0) : W + 2));
        chk("we_cycles", we_cnt, (cur.bad || !cur.we) ? 0 : W + 1);
        en_cnt = 0; oe_cnt = 0; we_cnt = 0;
      end
    end else if (!has) begin
      en_cnt = 0; oe_cnt = 0; we_cnt = 0;
    end
  end

  task automatic drive_junk(input bit hold);
    bus.req   = hold ? 1'b1 : 1'($urandom);
    bus.we    = 1'($urandom);
    bus.addr  = AW'($urandom);
    bus.wdata = DW'($urandom);
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic issue(input bit wr, input logic [SELW-1:0] bank, input logic [BAW-1:0] wa,
                       input logic [DW-1:0] wd, input bit hold);
    exp_t e;
    int   n = 0;
    while (!bus.ready && n < 60) begin
      drive_junk(hold);
      @(negedge clk);
      n++;
    end
    if (!bus.ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    bus.req = 1'b1; bus.we = wr; bus.addr = {bank, wa}; bus.wdata = wd;
    @(posedge clk);
    #1;
    e.acc = cyc; e.bank = int'(bank); e.bad = (int'(bank) >= NB); e.we = wr; e.wa = wa;
    if (e.bad) begin
      e.lat = 0; e.err = 1'b1;
    end else if (wr) begin
      rmem[bank][wa[3:0]] = wd & ~stuck[bank];
      if (VERIFY) begin
        last_rd = rmem[bank][wa[3:0]];
        e.err   = (last_rd != wd);
        e.lat   = 4 + 2 * W;
      end else begin
        e.err = 1'b0;
        e.lat = 2 + W;
      end
    end else begin
      last_rd = rmem[bank][wa[3:0]];
      e.err = 1'b0;
      e.lat = 2 + W;
    end
    e.rd = last_rd;
    q.push_back(e);
    if (hold) begin
      if (burst_prev >= 0) chk("b2b_spacing", cyc - burst_prev, 4 + W);
      burst_prev = cyc;
    end
    @(negedge clk);
    drive_junk(hold);
    if (!hold) bus.req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drive_junk(1'b0);
      bus.req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] saved;
    for (int b = 0; b < NB; b++) begin
      stuck[b] = '0;
      for (int i = 0; i < 16; i++) begin
        dmem[b][i] = DW'(b * 256 + i * 17);
        rmem[b][i] = DW'(b * 256 + i * 17);
      end
    end
    dmem[1][5] = 16'h1234;
    rmem[1][5] = 16'h1234;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;

    // Reset state.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", bus.ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_en_n", en_n, {NB{1'b1}});
    chk("rst_oe_n", oe_n, {NB{1'b1}});
    chk("rst_we_n", we_n, {NB{1'b1}});
    chk("rst_addr", raddr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Directed: write bank0, read bank1, bad bank, read-back bank0.
    issue(1'b1, 2'd0, 18'h5, 16'hBEEF, 1'b0);
    issue(1'b0, 2'd1, 18'h5, 16'h0, 1'b0);
    issue(1'b0, 2'd3, 18'h5, 16'h0, 1'b0);
    issue(1'b0, 2'd0, 18'h5, 16'h0, 1'b0);
    drain();

    // req held high: three back-to-back writes, then read them back.
    burst_prev = -1;
    issue(1'b1, 2'd2, 18'h3A001, 16'hA001, 1'b1);
    issue(1'b1, 2'd2, 18'h00002, 16'hA002, 1'b1);
    issue(1'b1, 2'd0, 18'h10003, 16'hA003, 1'b1);
    bus.req = 1'b0;
    drain();
    issue(1'b0, 2'd2, 18'h1, 16'h0, 1'b0);
    issue(1'b0, 2'd2, 18'h2, 16'h0, 1'b0);
    issue(1'b0, 2'd0, 18'h3, 16'h0, 1'b0);
    drain();

    // Stuck bit 0 on bank1: write 0x0001 reads back as 0x0000.
    stuck[1] = 16'h0001;
    issue(1'b1, 2'd1, 18'h7, 16'h0001, 1'b0);
    drain();
    stuck[1] = '0;
    issue(1'b0, 2'd1, 18'h7, 16'h0, 1'b0);
    drain();

    // Randomized traffic including out-of-range bank 3.
    for (int k = 0; k < 40; k++) begin
      issue(1'($urandom), 2'($urandom), BAW'($urandom), DW'($urandom), 1'b0);
      idle($urandom_range(0, 2));
    end
    drain();

    // Reset in the first ACCESS cycle of a write: dropped, no done, bus released.
    saved = rmem[0][9];
    issue(1'b1, 2'd0, 18'h9, 16'h5A5A, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    rmem[0][9] = saved;
    last_rd = '0;
    #1;
    chk("mid_rst_en_n", en_n, {NB{1'b1}});
    chk("mid_rst_oe_n", oe_n, {NB{1'b1}});
    chk("mid_rst_we_n", we_n, {NB{1'b1}});
    chk("mid_rst_ready", bus.ready, 1);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_rdata", bus.rdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    issue(1'b0, 2'd0, 18'h9, 16'h0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      issue(1'($urandom), 2'($urandom), BAW'($urandom), DW'($urandom), 1'b0);
    end
    drain();
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
